// File: rtl/axi2mem_pkg.sv
// Shared types, AXI response/burst encodings and the per-beat address step
// for the axi2mem AXI4-to-SRAM bridge.
package axi2mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_RESP = 3'd2,
    RD_MEM  = 3'd3,
    RD_DATA = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // WRAP advances like INCR; FIXED (and the reserved encoding) hold the address.
  function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    logic [63:0] step;
    step = 64'd1 << size;
    return (burst == BURST_INCR || burst == BURST_WRAP) ? addr + step : addr;
  endfunction

endpackage

// File: rtl/axi2mem.sv
// AXI4 slave to single-port SRAM bridge, one transaction in flight.
// Define AXI2MEM_ADDR_CHECK_EN to return DECERR for bursts starting outside the window.
module axi2mem
  import axi2mem_pkg::*;
#(
  parameter int unsigned           ID_WIDTH       = 8,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           MEM_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE       = '0
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [ID_WIDTH-1:0]       s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ID_WIDTH-1:0]       s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFFS       = $clog2(STRB_WIDTH);

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    dec_q, dec_d;
  logic                    last_rd_q, last_rd_d;
  logic                    rd_first_q, rd_first_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    grant_wr, grant_rd, start_dec;
  logic [ADDR_WIDTH-1:0]   addr_off, addr_nxt;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign grant_wr = s_axi_awvalid & (~s_axi_arvalid | last_rd_q);
  assign grant_rd = s_axi_arvalid & ~grant_wr;
  assign addr_nxt = ADDR_WIDTH'(next_addr(64'(addr_q), size_q, burst_q));
  assign addr_off = addr_q - MEM_BASE;
  assign rd_word  = dec_q ? '0 : mem_rdata_i;

`ifdef AXI2MEM_ADDR_CHECK_EN
  localparam logic [63:0] MEM_BYTES = 64'(STRB_WIDTH) << MEM_ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] start_addr;
  assign start_addr = grant_wr ? s_axi_awaddr : s_axi_araddr;
  assign start_dec  = (start_addr < MEM_BASE) ||
                      (64'(start_addr - MEM_BASE) >= MEM_BYTES);
`else
  assign start_dec = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      dec_q      <= 1'b0;
      last_rd_q  <= 1'b1;
      rd_first_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      dec_q      <= dec_d;
      last_rd_q  <= last_rd_d;
      rd_first_q <= rd_first_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    size_d     = size_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    dec_d      = dec_q;
    last_rd_d  = last_rd_q;
    rd_first_d = 1'b0;
    rdata_d    = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d   = WR_DATA;
          id_d      = s_axi_awid;
          addr_d    = s_axi_awaddr;
          size_d    = s_axi_awsize;
          burst_d   = s_axi_awburst;
          cnt_d     = s_axi_awlen;
          err_d     = 1'b0;
          dec_d     = start_dec;
          last_rd_d = 1'b0;
        end else if (grant_rd) begin
          state_d   = RD_MEM;
          id_d      = s_axi_arid;
          addr_d    = s_axi_araddr;
          size_d    = s_axi_arsize;
          burst_d   = s_axi_arburst;
          cnt_d     = s_axi_arlen;
          err_d     = 1'b0;
          dec_d     = start_dec;
          last_rd_d = 1'b1;
        end
      end
      WR_DATA: begin
        if (s_axi_wvalid) begin
          // The beat counter ends the burst; a misplaced wlast only flags the response.
          if (s_axi_wlast != (cnt_q == 8'd0)) err_d = 1'b1;
          if (cnt_q == 8'd0) begin
            state_d = WR_RESP;
          end else begin
            cnt_d  = cnt_q - 8'd1;
            addr_d = addr_nxt;
          end
        end
      end
      WR_RESP: begin
        if (s_axi_bready) state_d = IDLE;
      end
      RD_MEM: begin
        state_d    = RD_DATA;
        rd_first_d = 1'b1;
      end
      RD_DATA: begin
        // SRAM data is only valid in the first cycle; hold it for stalled beats.
        if (rd_first_q) rdata_d = rd_word;
        if (s_axi_rready) begin
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            state_d = RD_MEM;
            cnt_d   = cnt_q - 8'd1;
            addr_d  = addr_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_be_o      = '0;
    mem_wdata_o   = '0;
    unique case (state_q)
      IDLE: begin
        s_axi_awready = grant_wr;
        s_axi_arready = grant_rd;
      end
      WR_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && !dec_q) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_be_o    = s_axi_wstrb;
          mem_wdata_o = s_axi_wdata;
        end
      end
      WR_RESP: s_axi_bvalid = 1'b1;
      RD_MEM:  mem_req_o = ~dec_q;
      RD_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = (cnt_q == 8'd0);
      end
      default: ;
    endcase
  end

  assign mem_addr_o  = MEM_ADDR_WIDTH'(addr_off >> OFFS);
  assign s_axi_bid   = id_q;
  assign s_axi_bresp = dec_q ? RESP_DECERR : (err_q ? RESP_SLVERR : RESP_OKAY);
  assign s_axi_rid   = id_q;
  assign s_axi_rresp = dec_q ? RESP_DECERR : RESP_OKAY;
  assign s_axi_rdata = rd_first_q ? rd_word : rdata_q;

endmodule

// File: tb/tb_axi2mem.sv
// Scoreboard bench for axi2mem: directed transactions push expectations,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_axi2mem;
  import axi2mem_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [7:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst;
  logic        s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic        mem_req_o, mem_we_o;
  logic [11:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;

  always #5 clk_i = ~clk_i;

  axi2mem dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // Behavioural SRAM with one-cycle read latency.
  logic [31:0] mem [0:4095];
  always @(posedge clk_i) begin
    if (mem_req_o && mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
    if (mem_req_o && !mem_we_o) mem_rdata_i <= mem[mem_addr_o];
  end

  typedef struct { logic [11:0] addr; logic [3:0] be; logic [31:0] data; } wr_exp_t;
  typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
  typedef struct { string name; logic [63:0] act; logic [63:0] exp; } chk_t;

  wr_exp_t wq[$];
  b_exp_t  bq[$];
  r_exp_t  rq[$];
  chk_t    cq[$];
  bit      oq[$];
  int total = 0, bad = 0, r_done = 0, req_cnt = 0;
  logic        r_hold = 1'b0;
  logic [31:0] r_held;

  always @(negedge clk_i) begin
    chk_t c; wr_exp_t w; b_exp_t b; r_exp_t r; bit o;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      total++;
      if (c.act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", c.name, c.act, c.exp);
      end
    end
    if (!reset_ni) begin
      r_hold = 1'b0;
    end else begin
      if (mem_req_o) req_cnt++;
      if (mem_req_o && mem_we_o) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL mem_write unexpected: got addr=%0h data=%0h want none", mem_addr_o, mem_wdata_o);
        end else begin
          w = wq.pop_front();
          if ({mem_addr_o, mem_be_o, mem_wdata_o} !== {w.addr, w.be, w.data}) begin
            bad++;
            $display("FAIL mem_write: got addr=%0h be=%0h data=%0h want addr=%0h be=%0h data=%0h",
                     mem_addr_o, mem_be_o, mem_wdata_o, w.addr, w.be, w.data);
          end
        end
      end
      if (s_axi_awvalid && s_axi_awready && oq.size() > 0) begin
        o = oq.pop_front();
        total++;
        if (o != 1'b0) begin bad++; $display("FAIL grant_order: got write want read"); end
      end
      if (s_axi_arvalid && s_axi_arready && oq.size() > 0) begin
        o = oq.pop_front();
        total++;
        if (o != 1'b1) begin bad++; $display("FAIL grant_order: got read want write"); end
      end
      if (s_axi_bvalid && s_axi_bready) begin
        total++;
        if (bq.size() == 0) begin
          bad++;
          $display("FAIL bresp unexpected: got id=%0h resp=%0h want none", s_axi_bid, s_axi_bresp);
        end else begin
          b = bq.pop_front();
          if ({s_axi_bid, s_axi_bresp} !== {b.id, b.resp}) begin
            bad++;
            $display("FAIL bresp: got id=%0h resp=%0h want id=%0h resp=%0h",
                     s_axi_bid, s_axi_bresp, b.id, b.resp);
          end
        end
      end
      if (s_axi_rvalid) begin
        if (r_hold) begin
          total++;
          if (s_axi_rdata !== r_held) begin
            bad++;
            $display("FAIL rdata_stable: got %0h want %0h", s_axi_rdata, r_held);
          end
        end
        if (s_axi_rready) begin
          r_hold = 1'b0;
          r_done++;
          total++;
          if (rq.size() == 0) begin
            bad++;
            $display("FAIL rbeat unexpected: got id=%0h data=%0h want none", s_axi_rid, s_axi_rdata);
          end else begin
            r = rq.pop_front();
            if ({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} !== {r.id, r.data, r.resp, r.last}) begin
              bad++;
              $display("FAIL rbeat: got id=%0h data=%0h resp=%0h last=%0b want id=%0h data=%0h resp=%0h last=%0b",
                       s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, r.id, r.data, r.resp, r.last);
            end
          end
        end else begin
          r_hold = 1'b1;
          r_held = s_axi_rdata;
        end
      end else begin
        r_hold = 1'b0;
      end
    end
  end

  initial begin
    s_axi_rready = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      s_axi_rready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [31:0] base,
                           input logic [3:0] strb, input int early, input logic [1:0] resp);
    int n;
    logic [11:0] w;
    w = addr[13:2];
    for (int i = 0; i <= len; i++) begin
      wq.push_back('{w, strb, base + 32'(i)});
      if (burst != BURST_FIXED) w = w + 12'd1;
    end
    bq.push_back('{id, resp});
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = 3'd2; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    for (n = 0; n < 50; n++) begin @(negedge clk_i); if (s_axi_awready) break; end
    if (n == 50) cq.push_back('{"aw_timeout", 64'd0, 64'd1});
    @(posedge clk_i); #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = base + 32'(i); s_axi_wstrb = strb;
      s_axi_wlast = (i == len) || (i == early);
      for (n = 0; n < 50; n++) begin @(negedge clk_i); if (s_axi_wready) break; end
      if (n == 50) cq.push_back('{"w_timeout", 64'd0, 64'd1});
      @(posedge clk_i); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    for (n = 0; n < 50; n++) begin @(negedge clk_i); if (s_axi_bvalid && s_axi_bready) break; end
    if (n == 50) cq.push_back('{"b_timeout", 64'd0, 64'd1});
    @(posedge clk_i); #1;
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [31:0] base,
                          input logic [31:0] step, input logic [1:0] resp);
    int n, target;
    for (int i = 0; i <= len; i++)
      rq.push_back('{id, base + step * 32'(i), resp, (i == len)});
    target = r_done + len + 1;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = 3'd2; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    for (n = 0; n < 50; n++) begin @(negedge clk_i); if (s_axi_arready) break; end
    if (n == 50) cq.push_back('{"ar_timeout", 64'd0, 64'd1});
    @(posedge clk_i); #1;
    s_axi_arvalid = 1'b0;
    for (n = 0; n < 400; n++) begin @(negedge clk_i); if (r_done >= target) break; end
    if (n == 400) cq.push_back('{"r_timeout", 64'd0, 64'd1});
    @(posedge clk_i); #1;
  endtask

  initial begin
    int n, n0;
    reset_ni = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    repeat (3) @(posedge clk_i); #1;
    cq.push_back('{"reset_outputs", 64'({s_axi_awready, s_axi_arready, s_axi_wready,
                   s_axi_bvalid, s_axi_rvalid, mem_req_o}), 64'd0});
    cq.push_back('{"reset_rdata", 64'(s_axi_rdata), 64'd0});
    reset_ni = 1'b1;
    @(posedge clk_i); #1;

    axi_write(8'h5A, 32'h10, 0, BURST_INCR, 32'hDEADBEEF, 4'hF, -1, RESP_OKAY);
    axi_write(8'h01, 32'h00, 3, BURST_INCR, 32'h1, 4'hF, -1, RESP_OKAY);
    axi_read(8'h22, 32'h00, 3, BURST_INCR, 32'h1, 32'h1, RESP_OKAY);

    // Two ties after a read: write must win both.
    oq.push_back(1'b0); oq.push_back(1'b1); oq.push_back(1'b0); oq.push_back(1'b1);
    fork
      axi_write(8'h03, 32'h30, 0, BURST_INCR, 32'hA0, 4'hF, -1, RESP_OKAY);
      axi_read(8'h04, 32'h10, 0, BURST_INCR, 32'hDEADBEEF, 32'h0, RESP_OKAY);
    join
    fork
      axi_write(8'h05, 32'h34, 0, BURST_INCR, 32'hB0, 4'hF, -1, RESP_OKAY);
      axi_read(8'h06, 32'h30, 0, BURST_INCR, 32'hA0, 32'h0, RESP_OKAY);
    join

    axi_write(8'h07, 32'h100, 1, BURST_INCR, 32'h70, 4'hF, 0, RESP_SLVERR);
    axi_write(8'h08, 32'h10, 0, BURST_INCR, 32'h00001111, 4'h3, -1, RESP_OKAY);
    axi_read(8'h09, 32'h10, 0, BURST_INCR, 32'hDEAD1111, 32'h0, RESP_OKAY);
    axi_write(8'h0A, 32'h20, 1, BURST_FIXED, 32'hC0, 4'hF, -1, RESP_OKAY);
    axi_read(8'h0B, 32'h20, 1, BURST_FIXED, 32'hC1, 32'h0, RESP_OKAY);

    n0 = req_cnt;
`ifdef AXI2MEM_ADDR_CHECK_EN
    axi_read(8'h0C, 32'h0001_0000, 0, BURST_INCR, 32'h0, 32'h0, RESP_DECERR);
    cq.push_back('{"decerr_mem_req", 64'(req_cnt - n0), 64'd0});
`else
    axi_read(8'h0C, 32'h0001_0000, 0, BURST_INCR, 32'h1, 32'h0, RESP_OKAY);
    cq.push_back('{"alias_mem_req", 64'(req_cnt - n0), 64'd1});
`endif

    // Reset during the second beat of a four-beat write.
    s_axi_awid = 8'h0F; s_axi_awaddr = 32'h80; s_axi_awlen = 8'd3;
    s_axi_awsize = 3'd2; s_axi_awburst = BURST_INCR; s_axi_awvalid = 1'b1;
    wq.push_back('{12'h020, 4'hF, 32'h00000F00});
    for (n = 0; n < 50; n++) begin @(negedge clk_i); if (s_axi_awready) break; end
    if (n == 50) cq.push_back('{"aw_timeout", 64'd0, 64'd1});
    @(posedge clk_i); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h00000F00; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0;
    for (n = 0; n < 50; n++) begin @(negedge clk_i); if (s_axi_wready) break; end
    if (n == 50) cq.push_back('{"w_timeout", 64'd0, 64'd1});
    @(posedge clk_i); #1;
    s_axi_wdata = 32'h00000F01;
    #1 reset_ni = 1'b0;
    #1 cq.push_back('{"reset_midburst_outputs", 64'({s_axi_awready, s_axi_arready,
                      s_axi_wready, s_axi_bvalid, s_axi_rvalid, mem_req_o}), 64'd0});
    s_axi_wvalid = 1'b0;
    repeat (2) @(posedge clk_i); #1;
    reset_ni = 1'b1;
    repeat (10) @(posedge clk_i); #1;
    cq.push_back('{"no_b_after_reset", 64'(s_axi_bvalid), 64'd0});

    // First tie after reset goes to the write, so the read sees the new data.
    oq.push_back(1'b0); oq.push_back(1'b1);
    fork
      axi_write(8'h0D, 32'h40, 0, BURST_INCR, 32'h55AA1234, 4'hF, -1, RESP_OKAY);
      axi_read(8'h0E, 32'h40, 0, BURST_INCR, 32'h55AA1234, 32'h0, RESP_OKAY);
    join

    repeat (3) @(posedge clk_i); #1;
    cq.push_back('{"wq_left", 64'(wq.size()), 64'd0});
    cq.push_back('{"bq_left", 64'(bq.size()), 64'd0});
    cq.push_back('{"rq_left", 64'(rq.size()), 64'd0});
    cq.push_back('{"order_left", 64'(oq.size()), 64'd0});
    repeat (3) @(negedge clk_i);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi2mem.md
AXI2MEM -- requirements
Module: axi2mem

Interface
REQ-001 Parameter ID_WIDTH, default 8, AXI ID width.
REQ-002 Parameter ADDR_WIDTH, default 32, AXI byte-address width.
REQ-003 Parameter DATA_WIDTH, default 32, data width; STRB width = DATA_WIDTH/8.
REQ-004 Parameter MEM_ADDR_WIDTH, default 12, SRAM word-address width.
REQ-005 Parameter MEM_BASE, default 0, byte base address of the memory window.
REQ-006 clk_i  in  1  clock, rising edge; reset_ni  in  1  reset, asynchronous, active-low.
REQ-007 s_axi_aw{id,addr,len,size,burst,valid} in, s_axi_awready out  AXI4 write address; widths ID_WIDTH/ADDR_WIDTH/8/3/2/1/1.
REQ-008 s_axi_w{data,strb,last,valid} in, s_axi_wready out  write data; DATA_WIDTH/STRB/1/1/1.
REQ-009 s_axi_b{id,resp,valid} out, s_axi_bready in  write response; ID_WIDTH/2/1/1.
REQ-010 s_axi_ar{id,addr,len,size,burst,valid} in, s_axi_arready out  read address; same widths as AW.
REQ-011 s_axi_r{id,data,resp,last,valid} out, s_axi_rready in  read data; ID_WIDTH/DATA_WIDTH/2/1/1/1.
REQ-012 mem_req_o, mem_we_o (1), mem_addr_o (MEM_ADDR_WIDTH word address), mem_be_o (STRB), mem_wdata_o (DATA_WIDTH) out; mem_rdata_i (DATA_WIDTH) in  single-port SRAM, fixed 1-cycle read latency.

Function
REQ-013 FSM states IDLE, WR_DATA, WR_RESP, RD_MEM, RD_DATA; one transaction in flight, no outstanding overlap.
REQ-014 IDLE: awvalid and arvalid both high -> serve channel not served last (round-robin bit, reset value = read served last, so write wins first tie).
REQ-015 Address accept: awready/arready high exactly one cycle, in IDLE only, when that channel is granted; latch id, addr, len, size, burst; beat counter = len.
REQ-016 WR_DATA: wready=1; each w handshake drives mem_req_o=1, mem_we_o=1, mem_be_o=wstrb, mem_wdata_o=wdata same cycle; counter 0 -> WR_RESP.
REQ-017 WR_RESP: bvalid=1, bid=latched id, held stable until bready; then IDLE.
REQ-018 bresp=SLVERR(2'b10) if wlast disagreed with counter on any beat, else OKAY; beat count governs, wlast never ends a burst early.
REQ-019 RD_MEM: mem_req_o=1, mem_we_o=0 for one cycle -> RD_DATA; rdata registered from mem_rdata_i on next cycle.
REQ-020 RD_DATA: rvalid=1, rid=latched id, rlast=(counter==0), rresp=OKAY; data stable until rready; on handshake counter 0 -> IDLE else RD_MEM.
REQ-021 Address update per beat: INCR and WRAP add 1<<size; FIXED holds; WRAP treated as INCR.
REQ-022 mem_addr_o = (addr - MEM_BASE) >> log2(DATA_WIDTH/8), truncated to MEM_ADDR_WIDTH (wraps modulo memory size).
REQ-023 Throughput: read 2 cycles/beat minimum; write 1 cycle/beat.
REQ-024 mem_req_o=0 in IDLE, WR_RESP, RD_DATA.

Reset
REQ-025 reset_ni low asynchronously forces IDLE; all ready/valid and mem_req_o low; counters, latched fields, rdata register zero.
REQ-026 Reset mid-burst abandons transaction; no response issued after release.

Configuration
REQ-027 AXI2MEM_ADDR_CHECK_EN defined: burst start address outside [MEM_BASE, MEM_BASE + 2^MEM_ADDR_WIDTH*STRB) -> beats consumed/produced normally, mem_req_o suppressed, bresp/rresp=DECERR(2'b11), rdata=0.
REQ-028 AXI2MEM_ADDR_CHECK_EN undefined: no range check; out-of-range addresses alias per REQ-022; responses OKAY/SLVERR only.

Structure
REQ-029 Shared package axi2mem_pkg: state enum, AXI resp constants (OKAY, SLVERR, DECERR), burst constants (FIXED, INCR, WRAP).
REQ-030 Single module, no sub-module; address-increment logic is a function in the package.

Verification
REQ-031 Single write awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> mem write word 4, bresp=OKAY, bid echoed.
REQ-032 INCR read arlen=3 from 0x0 after preload 1,2,3,4 -> rdata 1,2,3,4, rlast only on 4th, rready toggled randomly, data stable while stalled.
REQ-033 awvalid and arvalid asserted same cycle twice -> write, read, write, read order.
REQ-034 Write awlen=1 with wlast on first beat -> two mem writes, bresp=SLVERR.
REQ-035 With AXI2MEM_ADDR_CHECK_EN, read arlen=0 at MEM_BASE+0x10000 (MEM_ADDR_WIDTH=12) -> no mem_req_o, rresp=DECERR, rdata=0.
REQ-036 reset_ni pulsed during WR_DATA beat 2 of 4 -> outputs low immediately, next write completes normally.
